tdm_demux4: RTL

- Receive-side counterpart of the 4:1 select mux: accepts a time-division stream in which a 4:1 mux has serialised four channels, one slot per valid beat, with slot 0 marked by a sync flag.
- Reconstructs the four channel words and presents them in parallel, registered, once per complete frame.
- Tracks frame alignment and counts alignment errors.
- Sits between the serialised link and the per-channel consumers; pairs with the mux/stimulus pair in loopback benches.

---
 rtl/tdm_demux4.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-slot TDM demultiplexer with frame alignment and error counting
//
// Takes a serialised stream of four channel words (one slot per valid beat,
// slot 0 flagged by sync_i) and presents each complete frame in parallel.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   din_valid         a slot word is present on din this cycle
//   sync_i            current beat is slot 0 (only meaningful with din_valid)
//   din[W]            serialised slot data
//   out0..out3[W]     channel words of the last complete frame
//   frame_valid       one-cycle pulse when out0..out3 are updated
//   frame_err         one-cycle pulse on an alignment error
//   locked            high while the aligner is in the LOCKED state
//   slot[2]           index of the next expected slot
//   err_cnt[CNT_W]    saturating count of frame_err pulses

module tdm_demux4 #(
    parameter int W     = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             sync_i,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     out0,
    output logic [W-1:0]     out1,
    output logic [W-1:0]     out2,
    output logic [W-1:0]     out3,
    output logic             frame_valid,
    output logic             frame_err,
    output logic             locked,
    output logic [1:0]       slot,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         slot_q, slot_d;
    logic [W-1:0]       sh0_q, sh0_d;
    logic [W-1:0]       sh1_q, sh1_d;
    logic [W-1:0]       sh2_q, sh2_d;
    logic [W-1:0]       out0_q, out0_d;
    logic [W-1:0]       out1_q, out1_d;
    logic [W-1:0]       out2_q, out2_d;
    logic [W-1:0]       out3_q, out3_d;
    logic               fv_q, fv_d;
    logic               fe_q, fe_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        out2_d  = out2_q;
        out3_d  = out3_q;
        fv_d    = 1'b0;
        fe_d    = 1'b0;
        cnt_d   = cnt_q;

        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (sync_i) begin
                        sh0_d   = din;
                        slot_d  = 2'd1;
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (slot_q == 2'd0) begin
                        if (sync_i) begin
                            sh0_d  = din;
                            slot_d = 2'd1;
                        end else begin
                            // Missing sync: drop the beat and go back to hunting.
                            fe_d    = 1'b1;
                            slot_d  = 2'd0;
                            state_d = ST_HUNT;
                        end
                    end else if (sync_i) begin
                        // Early sync: abandon the partial frame and restart
                        // alignment on this beat as slot 0.
                        fe_d   = 1'b1;
                        sh0_d  = din;
                        slot_d = 2'd1;
                    end else begin
                        case (slot_q)
                            2'd1: begin
                                sh1_d  = din;
                                slot_d = 2'd2;
                            end
                            2'd2: begin
                                sh2_d  = din;
                                slot_d = 2'd3;
                            end
                            default: begin
                                // Slot 3 goes straight to out3; no shadow needed.
                                out0_d = sh0_q;
                                out1_d = sh1_q;
                                out2_d = sh2_q;
                                out3_d = din;
                                fv_d   = 1'b1;
                                slot_d = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    slot_d  = 2'd0;
                end
            endcase
        end

        if (fe_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HUNT;
            slot_q  <= 2'd0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            out0_q  <= '0;
            out1_q  <= '0;
            out2_q  <= '0;
            out3_q  <= '0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
            out3_q  <= out3_d;
            fv_q    <= fv_d;
            fe_q    <= fe_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out0        = out0_q;
    assign out1        = out1_q;
    assign out2        = out2_q;
    assign out3        = out3_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign locked      = (state_q == ST_LOCKED);
    assign slot        = slot_q;
    assign err_cnt     = cnt_q;

endmodule
